// File: rtl/memory_stage.sv
// MEM pipeline stage: one data-memory access per cycle, registered 42-bit bundle to writeback.
// Reads are read-before-write; writes and the output register are suppressed while rst_n is low.
module memory_stage #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [75:0] MemoryInput,
  output logic [41:0] MemoryOutput
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [15:0]       store_data;
  logic [15:0]       mem_addr;
  logic [15:0]       result_a;
  logic [15:0]       result_b;
  logic [11:0]       ctrl;
  logic              mem_write;
  logic              mem_read;
  logic [ADDR_W-1:0] word_addr;

  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       wb_data;
  logic [41:0]       out_d;
  logic [41:0]       out_q;

  assign store_data = MemoryInput[75:60];
  assign mem_addr   = MemoryInput[59:44];
  assign result_a   = MemoryInput[43:28];
  assign result_b   = MemoryInput[27:12];
  assign ctrl       = MemoryInput[11:0];
  assign mem_write  = ctrl[5];
  assign mem_read   = ctrl[4];
  // Upper address bits are dropped so addresses wrap modulo the memory depth.
  assign word_addr  = mem_addr[ADDR_W-1:0];

  generate
    if (ADDR_W < 16) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^mem_addr[15:ADDR_W];
    end
  endgenerate

  // The combinational read sees the pre-edge contents, giving read-before-write.
  always_comb begin
    wb_data = result_a;
    if (mem_read) begin
      wb_data = mem_q[word_addr];
    end
    out_d = {wb_data, result_b, ctrl[11:6], ctrl[3:0]};
  end

  // Memory contents are never cleared; reset only blocks the write.
  always_ff @(posedge clk) begin
    if (rst_n && mem_write) begin
      mem_q[word_addr] <= store_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign MemoryOutput = out_q;

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios plus randomized traffic
// checked against an array-based model of the data memory.
module tb_memory_stage;

  localparam logic [11:0] C_WR   = 12'b101111100101;
  localparam logic [11:0] C_RD   = 12'b101111011001;
  localparam logic [11:0] C_NOP  = 12'b101111001001;
  localparam logic [11:0] C_RW   = 12'b101111111001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [75:0] mem_in;
  logic [41:0] mem_out;

  int total = 0;
  int bad   = 0;

  logic [15:0] ref_mem   [1024];
  bit          ref_valid [1024];

  memory_stage #(.ADDR_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .MemoryInput (mem_in),
    .MemoryOutput(mem_out)
  );

  always #5 clk = ~clk;

  // One normal (rst_n=1) transaction: predicts the output from the model, updates the
  // model, then applies the inputs across one rising edge and returns #1 after it.
  task automatic cycle(input logic [15:0] sd, input logic [15:0] addr,
                       input logic [15:0] ra, input logic [15:0] rb,
                       input logic [11:0] ctrl,
                       output logic [41:0] exp, output bit known);
    int          a;
    logic [15:0] wb;
    a     = int'(addr) % 1024;
    wb    = ctrl[4] ? ref_mem[a] : ra;
    known = !ctrl[4] || ref_valid[a];
    exp   = {wb, rb, ctrl[11:6], ctrl[3:0]};
    if (ctrl[5]) begin
      ref_mem[a]   = sd;
      ref_valid[a] = 1'b1;
    end
    rst_n  = 1'b1;
    mem_in = {sd, addr, ra, rb, ctrl};
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle(input logic [75:0] stim);
    rst_n  = 1'b0;
    mem_in = stim;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [41:0] e;
    bit          k;
    logic [75:0] stim;
    for (int i = 0; i < 2; i++) begin
      stim = {$urandom, $urandom, $urandom};
      reset_cycle(stim);
      total++;
      if (mem_out !== 42'h0) begin
        bad++;
        $display("FAIL reset_out[%0d]: got %h expected %h", i, mem_out, 42'h0);
      end
    end
    cycle(16'h1357, 16'd20, 16'h0, 16'h0, C_WR, e, k);
    reset_cycle({16'hFFFF, 16'd20, 16'h0, 16'h0, C_WR});
    total++;
    if (mem_out !== 42'h0) begin
      bad++;
      $display("FAIL reset_mid_out: got %h expected %h", mem_out, 42'h0);
    end
    cycle(16'h0, 16'd20, 16'h0, 16'h7, C_RD, e, k);
    total++;
    if (mem_out !== e || e[41:26] !== 16'h1357) begin
      bad++;
      $display("FAIL reset_write_blocked: got %h expected %h", mem_out, e);
    end
  endtask

  task automatic test_write_passthrough();
    logic [41:0] e;
    bit          k;
    cycle(16'h0, 16'd3, 16'd15, 16'd9, C_WR, e, k);
    total++;
    if (mem_out !== 42'b000000000000111100000000000010011011110101) begin
      bad++;
      $display("FAIL write_passthrough: got %b expected %b", mem_out,
               42'b000000000000111100000000000010011011110101);
    end
    cycle(16'h0, 16'd3, 16'd15, 16'd9, C_RD, e, k);
    total++;
    if (mem_out[41:26] !== 16'h0000) begin
      bad++;
      $display("FAIL write_zero_readback: got %h expected %h", mem_out[41:26], 16'h0000);
    end
  endtask

  task automatic test_write_read();
    logic [41:0] e;
    bit          k;
    cycle(16'hABCD, 16'd3, 16'd15, 16'd9, C_WR, e, k);
    cycle(16'h0, 16'd3, 16'd15, 16'd9, C_RD, e, k);
    total++;
    if (mem_out[41:26] !== 16'hABCD || mem_out[25:10] !== 16'd9 ||
        mem_out[9:0] !== 10'b1011111001) begin
      bad++;
      $display("FAIL write_read: got %h expected wb=abcd rb=0009 lo=%b", mem_out, 10'b1011111001);
    end
  endtask

  task automatic test_no_mem_op();
    logic [41:0] e;
    bit          k;
    cycle(16'hEEEE, 16'd3, 16'h1234, 16'h4321, C_NOP, e, k);
    total++;
    if (mem_out !== e || mem_out[41:26] !== 16'h1234) begin
      bad++;
      $display("FAIL no_mem_op: got %h expected %h", mem_out, e);
    end
    cycle(16'h0, 16'd3, 16'h0, 16'h0, C_RD, e, k);
    total++;
    if (mem_out[41:26] !== 16'hABCD) begin
      bad++;
      $display("FAIL no_mem_op_unchanged: got %h expected %h", mem_out[41:26], 16'hABCD);
    end
  endtask

  task automatic test_addr_wrap();
    logic [41:0] e;
    bit          k;
    cycle(16'h5A5A, 16'h0403, 16'h0, 16'h0, C_WR, e, k);
    cycle(16'h0, 16'h0003, 16'h0, 16'h0, C_RD, e, k);
    total++;
    if (mem_out[41:26] !== 16'h5A5A || mem_out !== e) begin
      bad++;
      $display("FAIL addr_wrap: got %h expected wb=5a5a (%h)", mem_out, e);
    end
  endtask

  task automatic test_simul_rw();
    logic [41:0] e;
    bit          k;
    cycle(16'h1111, 16'd7, 16'h0, 16'h0, C_WR, e, k);
    cycle(16'h2222, 16'd7, 16'hAAAA, 16'h0, C_RW, e, k);
    total++;
    if (mem_out[41:26] !== 16'h1111) begin
      bad++;
      $display("FAIL simul_rw_old: got %h expected %h", mem_out[41:26], 16'h1111);
    end
    cycle(16'h0, 16'd7, 16'h0, 16'h0, C_RD, e, k);
    total++;
    if (mem_out[41:26] !== 16'h2222) begin
      bad++;
      $display("FAIL simul_rw_new: got %h expected %h", mem_out[41:26], 16'h2222);
    end
  endtask

  task automatic test_back_to_back();
    logic [41:0] e;
    bit          k;
    logic [15:0] d;
    logic [15:0] a;
    for (int i = 0; i < 6; i++) begin
      d = 16'($urandom);
      a = 16'($urandom_range(100, 200));
      cycle(d, a, 16'($urandom), 16'($urandom), C_WR, e, k);
      cycle(16'($urandom), a, 16'($urandom), 16'($urandom), C_RD, e, k);
      total++;
      if (mem_out !== e || mem_out[41:26] !== d) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %h expected %h", i, mem_out, e);
      end
    end
  endtask

  task automatic test_random();
    logic [41:0] e;
    bit          k;
    logic [15:0] addr;
    for (int i = 0; i < 400; i++) begin
      addr = {6'($urandom), 10'($urandom_range(0, 15))};
      cycle(16'($urandom), addr, 16'($urandom), 16'($urandom), 12'($urandom), e, k);
      total++;
      if (k ? (mem_out !== e) : (mem_out[25:0] !== e[25:0])) begin
        bad++;
        $display("FAIL random[%0d]: got %h expected %h", i, mem_out, e);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    mem_in = '0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = '0;
      ref_valid[i] = 1'b0;
    end
    test_reset();
    test_write_passthrough();
    test_write_read();
    test_no_mem_op();
    test_addr_wrap();
    test_simul_rw();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
